// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency imem and
// presents {pc, instr, valid} to IF/ID, holding across stalls and killing on redirect.
module fetch_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0]   NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o,
  output logic            flush_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    KILL = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] pc_o_reg, pc_o_next;
  logic            valid_reg, valid_next;
  logic [XLEN-1:0] hold_reg, hold_next;
  logic            hold_v_reg, hold_v_next;

  // Low two bits of the redirect target are architecturally ignored.
  logic redirect_pc_unused;
  assign redirect_pc_unused = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= BOOT;
      pc_reg     <= RESET_PC;
      pc_o_reg   <= RESET_PC;
      valid_reg  <= 1'b0;
      hold_reg   <= NOP;
      hold_v_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      pc_o_reg   <= pc_o_next;
      valid_reg  <= valid_next;
      hold_reg   <= hold_next;
      hold_v_reg <= hold_v_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    pc_o_next   = pc_o_reg;
    valid_next  = valid_reg;
    hold_next   = hold_reg;
    hold_v_next = hold_v_reg;

    if (redirect_i) begin
      pc_next     = {redirect_pc[XLEN-1:2], 2'b00};
      valid_next  = 1'b0;
      hold_v_next = 1'b0;
      state_next  = KILL;
    end else begin
      case (state_reg)
        RUN: begin
          if (!stall_i) begin
            pc_o_next   = pc_reg;
            pc_next     = pc_reg + PC_STEP;
            hold_v_next = 1'b0;
          end else if (!hold_v_reg) begin
            // imem is about to return pc_reg's word, so keep pc_o's word now
            hold_next   = imem_rdata;
            hold_v_next = 1'b1;
          end
        end
        BOOT, KILL: begin
          pc_o_next   = pc_reg;
          pc_next     = pc_reg + PC_STEP;
          valid_next  = 1'b1;
          hold_v_next = 1'b0;
          state_next  = RUN;
        end
        default: begin
          valid_next  = 1'b0;
          hold_v_next = 1'b0;
          state_next  = BOOT;
        end
      endcase
    end
  end

  assign imem_addr  = pc_reg;
  assign pc_o       = pc_o_reg;
  assign pc_plus4_o = pc_o_reg + PC_STEP;
  assign valid_o    = valid_reg;
  assign instr_o    = !valid_reg ? NOP : (hold_v_reg ? hold_reg : imem_rdata);
  assign flush_o    = rst & redirect_i;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PCs are queued as stimulus is planned
// and popped whenever valid_o is seen; a second instance covers PC wrap and async reset.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst, stall, redirect;
  logic [31:0] rpc, imem_rdata, imem_addr, pc_o, pc_plus4_o, instr_o;
  logic        valid_o, flush_o;

  logic        rst2, stall2, redirect2;
  logic [31:0] rpc2, imem_rdata2, imem_addr2, pc_o2, pc_plus4_o2, instr_o2;
  logic        valid_o2, flush_o2;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP(NOP)) u_dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc(rpc), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .instr_o(instr_o),
    .valid_o(valid_o), .flush_o(flush_o)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .NOP(NOP)) u_dut_wrap (
    .clk(clk), .rst(rst2), .stall_i(stall2), .redirect_i(redirect2),
    .redirect_pc(rpc2), .imem_rdata(imem_rdata2), .imem_addr(imem_addr2),
    .pc_o(pc_o2), .pc_plus4_o(pc_plus4_o2), .instr_o(instr_o2),
    .valid_o(valid_o2), .flush_o(flush_o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // imem model: word at byte address A holds A (imem[k] = k*4), 1-cycle read
  initial begin
    imem_rdata  = 32'h0;
    imem_rdata2 = 32'h0;
  end
  always @(posedge clk) begin
    imem_rdata  <= imem_addr;
    imem_rdata2 <= imem_addr2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_q.push_back(pc);
  endtask

  // Scoreboard: every valid word must be the next expected PC with matching data
  always @(negedge clk) begin
    if (rst && valid_o) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 32'(valid_o), 32'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        $display("txn pc=%h instr=%h pc4=%h exp_pc=%h", pc_o, instr_o, pc_plus4_o, sb_exp);
        check("sb_pc", pc_o, sb_exp);
        check("sb_instr", instr_o, sb_exp);
        check("sb_pc4", pc_plus4_o, sb_exp + 32'd4);
      end
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b1; rpc = 32'h0000_0100;
    rst2 = 1'b0; stall2 = 1'b0; redirect2 = 1'b0; rpc2 = 32'h0;
    #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_instr", instr_o, NOP);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_flush_forced0", 32'(flush_o), 32'd0);
    tick(); tick();
    redirect = 1'b0;

    // T1: boot cycle then sequential fetch
    rst = 1'b1;
    push(32'h0); push(32'h4); push(32'h8); push(32'h8); push(32'h8); push(32'h8);
    push(32'hC); push(32'h10);
    #1;
    check("boot_valid", 32'(valid_o), 32'd0);
    check("boot_addr", imem_addr, 32'h0);
    tick();                         // c1 pc 0
    tick();                         // c2 pc 4
    tick(); stall = 1'b1;           // c3 pc 8, T2 stall begins
    tick();                         // c4
    tick();                         // c5
    tick(); stall = 1'b0;           // c6 still pc 8 (held word)
    tick();                         // c7 pc C
    tick();                         // c8 pc 10, T3 redirect
    push(32'h100); push(32'h104);
    redirect = 1'b1; rpc = 32'h0000_0100;
    #1;
    check("t3_flush", 32'(flush_o), 32'd1);
    tick(); redirect = 1'b0;        // c9 kill
    #1;
    check("t3_kill_valid", 32'(valid_o), 32'd0);
    check("t3_kill_instr", instr_o, NOP);
    check("t3_flush_low", 32'(flush_o), 32'd0);
    tick();                         // c10 pc 100
    tick(); stall = 1'b1;           // c11 pc 104, T4
    push(32'h104); push(32'h200); push(32'h204);
    tick();                         // c12 held 104, redirect misaligned
    redirect = 1'b1; rpc = 32'h0000_0203;
    #1;
    check("t4_flush", 32'(flush_o), 32'd1);
    tick(); redirect = 1'b0;        // c13 kill, stall still high
    #1;
    check("t4_kill_valid", 32'(valid_o), 32'd0);
    check("t4_kill_addr", imem_addr, 32'h200);
    tick(); stall = 1'b0;           // c14 pc 200
    tick();                         // c15 pc 204
    push(32'h208); push(32'h80); push(32'h84);
    tick();                         // c16 pc 208, T5
    redirect = 1'b1; rpc = 32'h0000_0040;
    tick(); rpc = 32'h0000_0080;    // c17
    #1;
    check("t5_kill1_valid", 32'(valid_o), 32'd0);
    tick(); redirect = 1'b0;        // c18
    #1;
    check("t5_kill2_valid", 32'(valid_o), 32'd0);
    check("t5_kill2_addr", imem_addr, 32'h80);
    tick();                         // c19 pc 80
    tick();                         // c20 pc 84
    tick();                         // c21: async reset before the sampling edge
    #2; rst = 1'b0;
    #1;
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_instr", instr_o, NOP);
    check("arst_pc", pc_o, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    // T6: wrap from RESET_PC = FFFF_FFF8, then async reset mid-stall
    tick(); rst2 = 1'b1;
    #1;
    check("w_boot_valid", 32'(valid_o2), 32'd0);
    check("w_boot_addr", imem_addr2, 32'hFFFF_FFF8);
    tick();
    check("w_c1_valid", 32'(valid_o2), 32'd1);
    check("w_c1_pc", pc_o2, 32'hFFFF_FFF8);
    check("w_c1_instr", instr_o2, 32'hFFFF_FFF8);
    check("w_c1_pc4", pc_plus4_o2, 32'hFFFF_FFFC);
    tick();
    check("w_c2_pc", pc_o2, 32'hFFFF_FFFC);
    check("w_c2_pc4", pc_plus4_o2, 32'h0);
    check("w_c2_instr", instr_o2, 32'hFFFF_FFFC);
    tick(); stall2 = 1'b1;
    check("w_c3_pc", pc_o2, 32'h0);
    check("w_c3_instr", instr_o2, 32'h0);
    check("w_c3_addr", imem_addr2, 32'h4);
    tick();
    check("w_stall_pc", pc_o2, 32'h0);
    check("w_stall_instr", instr_o2, 32'h0);
    check("w_stall_valid", 32'(valid_o2), 32'd1);
    #2; rst2 = 1'b0;
    #1;
    check("w_arst_valid", 32'(valid_o2), 32'd0);
    check("w_arst_instr", instr_o2, NOP);
    check("w_arst_pc", pc_o2, 32'hFFFF_FFF8);
    check("w_arst_addr", imem_addr2, 32'hFFFF_FFF8);
    check("w_arst_flush", 32'(flush_o2), 32'd0);
    tick();
    check("w_arst_hold_valid", 32'(valid_o2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
